// File: rtl/ctrl_pipe_decoder_pkg.sv
// Shared definitions for the pipelined control decoder.
// Holds the opcode map, ALU operation classes and the decoded control bundle.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    typedef struct packed {
        logic       branch_eq;
        logic       branch_ne;
        logic       alusrc;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       regdest;
        logic       jal;
        logic       jump;
        logic [2:0] aluop;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

endpackage

// File: rtl/ctrl_pipe_decoder_if.sv
// ID-stage inputs and per-stage control outputs of the pipelined decoder.
// The master side presents the instruction, the slave side is the decoder.
interface ctrl_pipe_decoder_if #(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 3
);
    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic [REG_W-1:0]    id_rd;
    logic                flush;
    logic                stall;
    logic                illegal_op;
    logic                ex_valid, ex_branch_eq, ex_branch_ne, ex_alusrc;
    logic                ex_memwrite, ex_memtoreg, ex_regwrite, ex_jal, ex_jump;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [REG_W-1:0]    ex_dest;
    logic                mem_valid, mem_memwrite, mem_memtoreg, mem_regwrite, mem_jal;
    logic [REG_W-1:0]    mem_dest;
    logic                wb_valid, wb_memtoreg, wb_regwrite, wb_jal;
    logic [REG_W-1:0]    wb_dest;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
        input  stall, illegal_op,
        input  ex_valid, ex_branch_eq, ex_branch_ne, ex_alusrc, ex_memwrite,
        input  ex_memtoreg, ex_regwrite, ex_jal, ex_jump, ex_aluop, ex_dest,
        input  mem_valid, mem_memwrite, mem_memtoreg, mem_regwrite, mem_jal, mem_dest,
        input  wb_valid, wb_memtoreg, wb_regwrite, wb_jal, wb_dest
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
        output stall, illegal_op,
        output ex_valid, ex_branch_eq, ex_branch_ne, ex_alusrc, ex_memwrite,
        output ex_memtoreg, ex_regwrite, ex_jal, ex_jump, ex_aluop, ex_dest,
        output mem_valid, mem_memwrite, mem_memtoreg, mem_regwrite, mem_jal, mem_dest,
        output wb_valid, wb_memtoreg, wb_regwrite, wb_jal, wb_dest
    );
endinterface

// File: rtl/ctrl_pipe_decoder_decode.sv
// Combinational opcode decoder: control bundle, rt-read flag and illegal flag.
// Extended-ISA opcodes are illegal unless EXT_ISA is set.
module ctrl_opcode_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter bit EXT_ISA  = 1'b0
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output logic                uses_rt_o,
    output logic                illegal_o
);

    // Opcode to control bundle; undefined opcodes leave the bundle all-zero.
    always_comb begin
        ctrl_o    = CTRL_NOP;
        uses_rt_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdest  = 1'b1;
                ctrl_o.aluop    = ALU_RTYPE;
                uses_rt_o       = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = ALU_ADD;
            end
            OP_LW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = ALU_ADD;
            end
            OP_SW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.aluop    = ALU_ADD;
                uses_rt_o       = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch_eq = 1'b1;
                ctrl_o.aluop     = ALU_SUB;
                uses_rt_o        = 1'b1;
            end
            OP_BNE: begin
                ctrl_o.branch_ne = 1'b1;
                ctrl_o.aluop     = ALU_SUB;
                uses_rt_o        = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.jal      = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
                if (EXT_ISA) begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    case (opcode_i)
                        OP_ANDI: ctrl_o.aluop = ALU_AND;
                        OP_ORI:  ctrl_o.aluop = ALU_OR;
                        OP_SLTI: ctrl_o.aluop = ALU_SLT;
                        default: ctrl_o.aluop = ALU_LUI;
                    endcase
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_J: begin
                if (EXT_ISA) begin
                    ctrl_o.jump = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Pipelined MIPS control decoder: decodes ID, detects load-use hazards and
// carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
module ctrl_pipe_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 3,
    parameter bit EXT_ISA  = 1'b0,
    parameter int LINK_REG = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ctrl_pipe_decoder_if.slave   bus
);

    typedef struct packed {
        logic               valid, branch_eq, branch_ne, alusrc, memwrite;
        logic               memtoreg, regwrite, jal, jump;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_W-1:0]   dest;
    } ex_stage_t;

    typedef struct packed {
        logic             valid, memwrite, memtoreg, regwrite, jal;
        logic [REG_W-1:0] dest;
    } mem_stage_t;

    typedef struct packed {
        logic             valid, memtoreg, regwrite, jal;
        logic [REG_W-1:0] dest;
    } wb_stage_t;

    localparam int EX_W  = $bits(ex_stage_t);
    localparam int MEM_W = $bits(mem_stage_t);
    localparam int WB_W  = $bits(wb_stage_t);
    localparam ex_stage_t  EX_NOP  = ex_stage_t'({EX_W{1'b0}});
    localparam mem_stage_t MEM_NOP = mem_stage_t'({MEM_W{1'b0}});
    localparam wb_stage_t  WB_NOP  = wb_stage_t'({WB_W{1'b0}});
    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    ctrl_t            dec_s;
    logic             uses_rt_s, undef_s, stall_s, bubble_s, regwrite_s;
    logic [REG_W-1:0] dest_s;
    ex_stage_t        ex_d, ex_q;
    mem_stage_t       mem_d, mem_q;
    wb_stage_t        wb_d, wb_q;
    logic             illegal_d, illegal_q;

    ctrl_opcode_decode #(
        .OPCODE_W (OPCODE_W),
        .EXT_ISA  (EXT_ISA)
    ) u_decode (
        .opcode_i  (bus.id_opcode),
        .ctrl_o    (dec_s),
        .uses_rt_o (uses_rt_s),
        .illegal_o (undef_s)
    );

    // Destination select; a write aimed at r0 is dropped here.
    always_comb begin
        if (dec_s.jal) begin
            dest_s = REG_W'(LINK_REG);
        end else if (dec_s.regdest) begin
            dest_s = bus.id_rd;
        end else begin
            dest_s = bus.id_rt;
        end
        regwrite_s = dec_s.regwrite & (dest_s != REG_ZERO);
    end

    assign stall_s = ex_q.valid & ex_q.memtoreg & (ex_q.dest != REG_ZERO) & bus.id_valid &
                     ((ex_q.dest == bus.id_rs) | (uses_rt_s & (ex_q.dest == bus.id_rt)));
    assign bubble_s  = ~bus.id_valid | stall_s | bus.flush | undef_s;
    assign illegal_d = bus.id_valid & undef_s & ~bus.flush & ~stall_s;

    // ID/EX next state: decoded bundle or bubble.
    always_comb begin
        ex_d = EX_NOP;
        if (bubble_s) begin
            ex_d = EX_NOP;
        end else begin
            ex_d.valid     = 1'b1;
            ex_d.branch_eq = dec_s.branch_eq;
            ex_d.branch_ne = dec_s.branch_ne;
            ex_d.alusrc    = dec_s.alusrc;
            ex_d.memwrite  = dec_s.memwrite;
            ex_d.memtoreg  = dec_s.memtoreg;
            ex_d.regwrite  = regwrite_s;
            ex_d.jal       = dec_s.jal;
            ex_d.jump      = dec_s.jump;
            ex_d.aluop     = ALUOP_W'(dec_s.aluop);
            ex_d.dest      = dest_s;
        end
    end

    // Later stages keep only write-back-relevant fields and always advance.
    always_comb begin
        mem_d = '{valid: ex_q.valid, memwrite: ex_q.memwrite, memtoreg: ex_q.memtoreg,
                  regwrite: ex_q.regwrite, jal: ex_q.jal, dest: ex_q.dest};
        wb_d  = '{valid: mem_q.valid, memtoreg: mem_q.memtoreg,
                  regwrite: mem_q.regwrite, jal: mem_q.jal, dest: mem_q.dest};
    end

    // Stage registers with asynchronous clear to bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q      <= EX_NOP;
            mem_q     <= MEM_NOP;
            wb_q      <= WB_NOP;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.stall        = stall_s;
    assign bus.illegal_op   = illegal_q;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_branch_eq = ex_q.branch_eq;
    assign bus.ex_branch_ne = ex_q.branch_ne;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_jal       = ex_q.jal;
    assign bus.ex_jump      = ex_q.jump;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_dest      = ex_q.dest;
    assign bus.mem_valid    = mem_q.valid;
    assign bus.mem_memwrite = mem_q.memwrite;
    assign bus.mem_memtoreg = mem_q.memtoreg;
    assign bus.mem_regwrite = mem_q.regwrite;
    assign bus.mem_jal      = mem_q.jal;
    assign bus.mem_dest     = mem_q.dest;
    assign bus.wb_valid     = wb_q.valid;
    assign bus.wb_memtoreg  = wb_q.memtoreg;
    assign bus.wb_regwrite  = wb_q.regwrite;
    assign bus.wb_jal       = wb_q.jal;
    assign bus.wb_dest      = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Scoreboard bench for ctrl_pipe_decoder: one instance per EXT_ISA setting,
// both driven with the same instruction stream and checked against a bench model.
module tb_ctrl_pipe_decoder;

    typedef struct packed {
        logic v, beq, bne, asrc, mw, m2r, rw, jal, jmp;
        logic [2:0] aop;
        logic [4:0] dst;
    } ex_t;

    typedef struct packed {
        ex_t  ex;
        logic ill;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_t  m_ex [2];
    ex_t  m_mem [2];
    ex_t  m_wb [2];
    logic m_ill [2];
    sb_t  sb0 [$];
    sb_t  sb1 [$];

    ctrl_pipe_decoder_if #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(3)) bus0 ();
    ctrl_pipe_decoder_if #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(3)) bus1 ();

    ctrl_pipe_decoder #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(3), .EXT_ISA(1'b0), .LINK_REG(31))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    ctrl_pipe_decoder #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(3), .EXT_ISA(1'b1), .LINK_REG(31))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t dut_ex(input int k);
        if (k == 0)
            return {bus0.ex_valid, bus0.ex_branch_eq, bus0.ex_branch_ne, bus0.ex_alusrc,
                    bus0.ex_memwrite, bus0.ex_memtoreg, bus0.ex_regwrite, bus0.ex_jal,
                    bus0.ex_jump, bus0.ex_aluop, bus0.ex_dest};
        else
            return {bus1.ex_valid, bus1.ex_branch_eq, bus1.ex_branch_ne, bus1.ex_alusrc,
                    bus1.ex_memwrite, bus1.ex_memtoreg, bus1.ex_regwrite, bus1.ex_jal,
                    bus1.ex_jump, bus1.ex_aluop, bus1.ex_dest};
    endfunction

    function automatic ex_t dut_mem(input int k);
        ex_t r = ex_t'(0);
        if (k == 0) begin
            r.v = bus0.mem_valid; r.mw = bus0.mem_memwrite; r.m2r = bus0.mem_memtoreg;
            r.rw = bus0.mem_regwrite; r.jal = bus0.mem_jal; r.dst = bus0.mem_dest;
        end else begin
            r.v = bus1.mem_valid; r.mw = bus1.mem_memwrite; r.m2r = bus1.mem_memtoreg;
            r.rw = bus1.mem_regwrite; r.jal = bus1.mem_jal; r.dst = bus1.mem_dest;
        end
        return r;
    endfunction

    function automatic ex_t dut_wb(input int k);
        ex_t r = ex_t'(0);
        if (k == 0) begin
            r.v = bus0.wb_valid; r.m2r = bus0.wb_memtoreg; r.rw = bus0.wb_regwrite;
            r.jal = bus0.wb_jal; r.dst = bus0.wb_dest;
        end else begin
            r.v = bus1.wb_valid; r.m2r = bus1.wb_memtoreg; r.rw = bus1.wb_regwrite;
            r.jal = bus1.wb_jal; r.dst = bus1.wb_dest;
        end
        return r;
    endfunction

    function automatic ex_t keep_mem(input ex_t e);
        ex_t r = e;
        r.beq = 1'b0; r.bne = 1'b0; r.asrc = 1'b0; r.jmp = 1'b0; r.aop = 3'd0;
        return r;
    endfunction

    function automatic ex_t keep_wb(input ex_t e);
        ex_t r = keep_mem(e);
        r.mw = 1'b0;
        return r;
    endfunction

    // Reference decode written from the opcode table.
    task automatic mdec(input bit ext, input logic [5:0] op, input logic [4:0] rt,
                        input logic [4:0] rd, output ex_t d, output logic und, output logic urt);
        d = ex_t'(0); und = 1'b0; urt = 1'b0;
        d.v = 1'b1; d.dst = rt;
        case (op)
            6'h00: begin d.rw = 1'b1; d.aop = 3'd2; d.dst = rd; urt = 1'b1; end
            6'h08: begin d.asrc = 1'b1; d.rw = 1'b1; end
            6'h23: begin d.asrc = 1'b1; d.m2r = 1'b1; d.rw = 1'b1; end
            6'h2b: begin d.asrc = 1'b1; d.mw = 1'b1; urt = 1'b1; end
            6'h04: begin d.beq = 1'b1; d.aop = 3'd1; urt = 1'b1; end
            6'h05: begin d.bne = 1'b1; d.aop = 3'd1; urt = 1'b1; end
            6'h03: begin d.rw = 1'b1; d.jal = 1'b1; d.dst = 5'd31; end
            6'h0c: if (ext) begin d.asrc = 1'b1; d.rw = 1'b1; d.aop = 3'd3; end else und = 1'b1;
            6'h0d: if (ext) begin d.asrc = 1'b1; d.rw = 1'b1; d.aop = 3'd4; end else und = 1'b1;
            6'h0a: if (ext) begin d.asrc = 1'b1; d.rw = 1'b1; d.aop = 3'd5; end else und = 1'b1;
            6'h0f: if (ext) begin d.asrc = 1'b1; d.rw = 1'b1; d.aop = 3'd6; end else und = 1'b1;
            6'h02: if (ext) d.jmp = 1'b1; else und = 1'b1;
            default: und = 1'b1;
        endcase
        if (d.dst == 5'd0) d.rw = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        bus0.id_valid = v; bus0.id_opcode = op; bus0.id_rs = rs; bus0.id_rt = rt;
        bus0.id_rd = rd; bus0.flush = fl;
        bus1.id_valid = v; bus1.id_opcode = op; bus1.id_rs = rs; bus1.id_rt = rt;
        bus1.id_rd = rd; bus1.flush = fl;
    endtask

    task automatic compare_all(input int k);
        check_eq($sformatf("ex%0d", k), 32'(dut_ex(k)), 32'(m_ex[k]));
        check_eq($sformatf("mem%0d", k), 32'(dut_mem(k)), 32'(m_mem[k]));
        check_eq($sformatf("wb%0d", k), 32'(dut_wb(k)), 32'(m_wb[k]));
        check_eq($sformatf("illegal%0d", k), 32'(k == 0 ? bus0.illegal_op : bus1.illegal_op),
                 32'(m_ill[k]));
    endtask

    // One ID cycle: check stall, push expected EX content, then check all stages after the edge.
    task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        @(negedge clk);
        drive(v, op, rs, rt, rd, fl);
        #1;
        for (int k = 0; k < 2; k++) begin
            ex_t d; logic und, urt, st; sb_t e;
            mdec(k == 1, op, rt, rd, d, und, urt);
            st = m_ex[k].v & m_ex[k].m2r & (m_ex[k].dst != 5'd0) & v &
                 ((m_ex[k].dst == rs) | (urt & (m_ex[k].dst == rt)));
            check_eq($sformatf("stall%0d", k), 32'(k == 0 ? bus0.stall : bus1.stall), 32'(st));
            e.ex  = (!v || st || fl || und) ? ex_t'(0) : d;
            e.ill = v & und & !fl & !st;
            if (k == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            sb_t e;
            if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
                m_wb[k]  = keep_wb(m_mem[k]);
                m_mem[k] = keep_mem(m_ex[k]);
                m_ex[k]  = e.ex;
                m_ill[k] = e.ill;
                compare_all(k);
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = ex_t'(0); m_mem[k] = ex_t'(0); m_wb[k] = ex_t'(0); m_ill[k] = 1'b0;
        end
        sb0.delete(); sb1.delete();
    endtask

    task automatic reset_check();
        model_clear();
        for (int k = 0; k < 2; k++) begin
            compare_all(k);
            check_eq($sformatf("rst_stall%0d", k), 32'(k == 0 ? bus0.stall : bus1.stall), 32'd0);
        end
    endtask

    initial begin
        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        model_clear();
        #2 reset_n = 1'b0;
        #1 reset_check();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD, LW, ADDI back to back, then drain
        step(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b1, 6'h23, 5'd1, 5'd4, 5'd0, 1'b0);
        step(1'b1, 6'h08, 5'd1, 5'd6, 5'd0, 1'b0);
        step(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        // load-use on rt: SW held for one cycle
        step(1'b1, 6'h23, 5'd2, 5'd5, 5'd0, 1'b0);
        step(1'b1, 6'h2b, 5'd1, 5'd5, 5'd0, 1'b0);
        step(1'b1, 6'h2b, 5'd1, 5'd5, 5'd0, 1'b0);
        // load to r0 never stalls and never writes
        step(1'b1, 6'h23, 5'd2, 5'd0, 5'd0, 1'b0);
        step(1'b1, 6'h00, 5'd0, 5'd7, 5'd8, 1'b0);
        // R-type writing r0
        step(1'b1, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        // JAL, then extended-ISA opcodes (illegal on the base decoder)
        step(1'b1, 6'h03, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 6'h0d, 5'd1, 5'd9, 5'd0, 1'b0);
        step(1'b1, 6'h0c, 5'd1, 5'd9, 5'd0, 1'b0);
        step(1'b1, 6'h0a, 5'd1, 5'd10, 5'd0, 1'b0);
        step(1'b1, 6'h0f, 5'd0, 5'd11, 5'd0, 1'b0);
        step(1'b1, 6'h02, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 6'h3f, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 6'h3f, 5'd0, 5'd0, 5'd0, 1'b1);
        // branches: load-use on rt for BEQ, rs for ADDI, none for BNE
        step(1'b1, 6'h23, 5'd1, 5'd12, 5'd0, 1'b0);
        step(1'b1, 6'h04, 5'd3, 5'd12, 5'd0, 1'b0);
        step(1'b1, 6'h04, 5'd3, 5'd12, 5'd0, 1'b0);
        step(1'b1, 6'h23, 5'd1, 5'd13, 5'd0, 1'b0);
        step(1'b1, 6'h08, 5'd13, 5'd14, 5'd0, 1'b0);
        step(1'b1, 6'h08, 5'd13, 5'd14, 5'd0, 1'b0);
        step(1'b1, 6'h05, 5'd2, 5'd3, 5'd0, 1'b0);
        // flush together with a load-use hazard, then normal decode
        step(1'b1, 6'h23, 5'd1, 5'd10, 5'd0, 1'b0);
        step(1'b1, 6'h00, 5'd10, 5'd2, 5'd11, 1'b1);
        step(1'b1, 6'h00, 5'd3, 5'd4, 5'd11, 1'b0);
        // undefined opcode under a stall is not flagged
        step(1'b1, 6'h23, 5'd1, 5'd15, 5'd0, 1'b0);
        step(1'b1, 6'h3e, 5'd15, 5'd0, 5'd0, 1'b0);
        // LW enters EX, then reset mid-stream
        step(1'b1, 6'h23, 5'd1, 5'd14, 5'd0, 1'b0);
        step(1'b1, 6'h00, 5'd1, 5'd2, 5'd16, 1'b0);
        @(negedge clk);
        drive(1'b1, 6'h00, 5'd14, 5'd14, 5'd17, 1'b0);
        #2 reset_n = 1'b0;
        drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 reset_check();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 6'h00, 5'd14, 5'd14, 5'd18, 1'b0);
        step(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
